// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Size codes, FSM states, port ids and the latched request.
package dm_pkg;

  localparam int DM_WORDS_DEF = 4096;
  localparam int ADDR_W_DEF   = 12;

  localparam logic [2:0] SZ_WORD = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_BYTE = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } port_t;

  typedef struct packed {
    port_t       port;
    logic        we;
    logic [2:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dm_lane_unit.sv
// Byte-lane steering for one access: store enables and
// replication, load lane extraction and extension.
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        uns,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
  assign lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Decode size; misalign also covers illegal size codes.
  always_comb begin
    be        = 4'h0;
    wdata_rep = 32'h0;
    rdata_ext = 32'h0;
    misalign  = 1'b0;
    unique case (1'b1)
      size == SZ_WORD: begin
        be        = 4'hF;
        wdata_rep = wdata;
        rdata_ext = rdata;
        misalign  = addr_lo != 2'b00;
      end
      size == SZ_HALF: begin
        be        = addr_lo[1] ? 4'hC : 4'h3;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = uns ? {16'h0, lane_h}
                        : {{16{lane_h[15]}}, lane_h};
        misalign  = addr_lo[0];
      end
      size == SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = uns ? {24'h0, lane_b}
                        : {{24{lane_b[7]}}, lane_b};
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin sharing of the data-memory SRAM between
// the CPU MEM stage (c) and the bridge/DMA port (d).
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [2:0]        c_size,
  input  logic              c_uns,
  input  logic [31:0]       c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_done,
  output logic [31:0]       c_rdata,
  output logic              c_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_size,
  input  logic              d_uns,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t      state;
  req_t        req;
  req_t        pick;
  port_t       last_grant;
  logic        r_err;
  logic        grant_d;
  logic        misalign;
  logic        range_err;
  logic        fault;
  logic        access;
  logic [3:0]  be;
  logic [31:0] wrep;
  logic [31:0] rext;
  logic [31:0] rdata_q;

  dm_lane_unit u_lane (
    .size      (req.size),
    .addr_lo   (req.addr[1:0]),
    .wdata     (req.wdata),
    .rdata     (mem_rdata),
    .uns       (req.uns),
    .be        (be),
    .wdata_rep (wrep),
    .rdata_ext (rext),
    .misalign  (misalign)
  );

  assign range_err = (req.addr[31:ADDR_W+2] != '0) ||
                     (req.addr[31:2] >= 30'(DM_WORDS));
  assign fault     = misalign | range_err;

  // d wins only alone or when c was served last.
  assign grant_d = d_req & (~c_req | (last_grant == PORT_C));

  // Snapshot of the winning port's fields.
  always_comb begin
    pick = '0;
    if (grant_d) begin
      pick.port  = PORT_D;
      pick.we    = d_we;
      pick.size  = d_size;
      pick.uns   = d_uns;
      pick.addr  = d_addr;
      pick.wdata = d_wdata;
    end else begin
      pick.port  = PORT_C;
      pick.we    = c_we;
      pick.size  = c_size;
      pick.uns   = c_uns;
      pick.addr  = c_addr;
      pick.wdata = c_wdata;
    end
  end

  // A reset landing in CHECK must not reach the SRAM.
  assign access    = (state == CHECK) & ~fault & ~reset;
  assign mem_en    = access;
  assign mem_be    = (access & req.we) ? be : 4'h0;
  assign mem_addr  = access ? req.addr[ADDR_W+1:2] : '0;
  assign mem_wdata = (access & req.we) ? wrep : 32'h0;

  assign rdata_q = (state == RESP && !r_err && !req.we)
                   ? rext : 32'h0;
  assign c_rdata = (req.port == PORT_C) ? rdata_q : 32'h0;
  assign d_rdata = (req.port == PORT_D) ? rdata_q : 32'h0;

  // Access sequencer: IDLE latches, CHECK probes, RESP answers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req        <= '0;
      last_grant <= PORT_D;
      r_err      <= 1'b0;
      c_done     <= 1'b0;
      c_err      <= 1'b0;
      d_done     <= 1'b0;
      d_err      <= 1'b0;
    end else begin
      c_done <= 1'b0;
      c_err  <= 1'b0;
      d_done <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (c_req | d_req) begin
            req   <= pick;
            state <= CHECK;
          end
        end
        CHECK: begin
          r_err <= fault;
          if (req.port == PORT_C) begin
            c_done <= 1'b1;
            c_err  <= fault;
          end else begin
            d_done <= 1'b1;
            d_err  <= fault;
          end
          state <= RESP;
        end
        RESP: begin
          last_grant <= req.port;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomised bench for dm_arbiter against a
// byte-addressed transaction model with cycle timing.
module tb_dm_arbiter;

  typedef struct {
    bit        we;
    bit [2:0]  size;
    bit        uns;
    bit [31:0] addr;
    bit [31:0] wdata;
    int        gap;
  } tx_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        c_req = 0, c_we = 0, c_uns = 0;
  logic [2:0]  c_size = 0;
  logic [31:0] c_addr = 0, c_wdata = 0;
  logic        d_req = 0, d_we = 0, d_uns = 0;
  logic [2:0]  d_size = 0;
  logic [31:0] d_addr = 0, d_wdata = 0;
  logic        c_done, c_err, d_done, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        mem_en;
  logic [3:0]  mem_be;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_size(c_size),
    .c_uns(c_uns), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_done(c_done), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size),
    .d_uns(d_uns), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] sram [0:4095] = '{default: 32'h0};

  function automatic logic [31:0] merge(
    logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      sram[mem_addr] <= merge(sram[mem_addr], mem_wdata, mem_be);
      mem_rdata      <= sram[mem_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               tag, got, exp, k);
    end
  endtask

  logic [7:0] ref_b [0:16383] = '{default: 8'h00};
  tx_t cur [2];
  bit  act [2] = '{0, 0};
  bit  have [2] = '{0, 0};
  bit  granted [2] = '{0, 0};
  int  gapc [2] = '{0, 0};
  tx_t q0 [$];
  tx_t q1 [$];

  bit        p_valid = 0;
  bit        p_port;
  tx_t       p;
  bit        p_fault;
  bit [31:0] p_rdata;
  int        chk_cyc, done_cyc;
  int        free_cyc = 0;
  bit        last_port = 1;
  bit        inject_armed = 0;
  bit        reset_pulse = 0;

  function automatic int nbytes(bit [2:0] s);
    return s == 3'd0 ? 4 : (s == 3'd1 ? 2 : 1);
  endfunction

  function automatic bit is_fault(tx_t t);
    if (t.size > 3'd2) return 1;
    if (t.addr % nbytes(t.size) != 0) return 1;
    return t.addr >= 32'h4000;
  endfunction

  function automatic tx_t mk(bit we, bit [2:0] sz, bit u,
                             bit [31:0] a, bit [31:0] w);
    tx_t t;
    t.we = we; t.size = sz; t.uns = u;
    t.addr = a; t.wdata = w; t.gap = 0;
    return t;
  endfunction

  function automatic tx_t rand_tx();
    tx_t t;
    int r;
    t.we = 1'($urandom_range(0, 1));
    t.uns = 1'($urandom_range(0, 1));
    r = int'($urandom_range(0, 15));
    if (r < 5) t.size = 3'd0;
    else if (r < 10) t.size = 3'd1;
    else if (r < 14) t.size = 3'd2;
    else t.size = 3'($urandom_range(3, 7));
    if ($urandom_range(0, 7) == 0) t.addr = $urandom;
    else t.addr = $urandom_range(0, 63);
    t.wdata = $urandom;
    t.gap = ($urandom_range(0, 3) == 0)
            ? int'($urandom_range(1, 4)) : 0;
    return t;
  endfunction

  task automatic observe();
    bit e_en, e_cd, e_dd;
    bit [3:0] e_be;
    bit [31:0] e_wd, v, rep;
    int nb;
    if (reset_pulse) begin
      chk("rst_c_done", 32'(c_done), 0);
      chk("rst_d_done", 32'(d_done), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      reset = 1'b0;
      reset_pulse = 0;
      free_cyc = k;
      return;
    end
    e_en = 0; e_be = 0; e_wd = 0;
    nb = nbytes(p.size);
    if (p_valid && k == chk_cyc && !p_fault) begin
      e_en = 1;
      for (int j = 0; j < 4; j++)
        rep[8*j +: 8] = p.wdata[8*(j % nb) +: 8];
      for (int i = 0; i < nb; i++)
        e_be[(p.addr + i) % 4] = 1'b1;
      if (!p.we) e_be = 0;
      e_wd = p.we ? rep : 32'h0;
    end
    chk("mem_en", 32'(mem_en), 32'(e_en));
    if (e_en) begin
      chk("mem_be", 32'(mem_be), 32'(e_be));
      chk("mem_addr", 32'(mem_addr), p.addr / 4);
      chk("mem_wdata", mem_wdata, e_wd);
    end
    if (p_valid && k == chk_cyc) begin
      if (inject_armed && p_port && p.we) begin
        p_valid = 0;
        act[1] = 0;
        granted[1] = 0;
        inject_armed = 0;
        reset = 1'b1;
        reset_pulse = 1;
        last_port = 1;
      end else if (!p_fault) begin
        if (p.we) begin
          for (int i = 0; i < nb; i++)
            ref_b[p.addr + i] = p.wdata[8*i +: 8];
        end else begin
          v = 0;
          for (int i = 0; i < nb; i++)
            v |= 32'(ref_b[p.addr + i]) << (8 * i);
          if (!p.uns && nb < 4 && v[8*nb-1])
            v |= ~((32'h1 << (8 * nb)) - 1);
          p_rdata = v;
        end
      end
    end
    e_cd = p_valid && k == done_cyc && !p_port;
    e_dd = p_valid && k == done_cyc && p_port;
    v = (p.we || p_fault) ? 32'h0 : p_rdata;
    chk("c_done", 32'(c_done), 32'(e_cd));
    chk("d_done", 32'(d_done), 32'(e_dd));
    chk("c_err", 32'(c_err), 32'(e_cd && p_fault));
    chk("d_err", 32'(d_err), 32'(e_dd && p_fault));
    chk("c_rdata", c_rdata, e_cd ? v : 32'h0);
    chk("d_rdata", d_rdata, e_dd ? v : 32'h0);
    if (p_valid && k == done_cyc) begin
      p_valid = 0;
      free_cyc = k + 1;
      act[p_port] = 0;
      granted[p_port] = 0;
    end
  endtask

  task automatic drivers();
    for (int i = 0; i < 2; i++) begin
      if (act[i] && granted[i]) begin
        cur[i].addr = $urandom;
        cur[i].wdata = $urandom;
        cur[i].size = 3'($urandom);
        cur[i].we = 1'($urandom);
      end else if (!act[i]) begin
        if (!have[i] && (i == 0 ? q0.size() : q1.size()) > 0) begin
          if (i == 0) cur[0] = q0.pop_front();
          else cur[1] = q1.pop_front();
          have[i] = 1;
          gapc[i] = cur[i].gap;
        end
        if (have[i]) begin
          if (gapc[i] > 0) gapc[i]--;
          else begin
            act[i] = 1;
            have[i] = 0;
          end
        end
      end
    end
    c_req = act[0]; c_we = cur[0].we; c_size = cur[0].size;
    c_uns = cur[0].uns; c_addr = cur[0].addr;
    c_wdata = cur[0].wdata;
    d_req = act[1]; d_we = cur[1].we; d_size = cur[1].size;
    d_uns = cur[1].uns; d_addr = cur[1].addr;
    d_wdata = cur[1].wdata;
  endtask

  task automatic model_arb();
    bit w;
    if (!p_valid && k >= free_cyc && !reset &&
        (act[0] || act[1])) begin
      w = (act[0] && act[1]) ? !last_port : act[1];
      p = cur[w];
      p_port = w;
      p_valid = 1;
      p_fault = is_fault(p);
      chk_cyc = k + 1;
      done_cyc = k + 2;
      last_port = w;
      granted[w] = 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    k++;
    observe();
    drivers();
    model_arb();
  endtask

  task automatic drain(int maxc);
    int n = 0;
    while ((act[0] || act[1] || have[0] || have[1] || p_valid ||
            q0.size() > 0 || q1.size() > 0 || reset_pulse) &&
           n < maxc) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 32'(n >= maxc), 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("rst_c_done", 32'(c_done), 0);
    chk("rst_c_err", 32'(c_err), 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_d_done", 32'(d_done), 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    k = 0;
    q0.push_back(mk(1, 3'd0, 0, 32'h10, 32'h12345678));
    q0.push_back(mk(0, 3'd0, 0, 32'h10, 32'h0));
    q0.push_back(mk(0, 3'd2, 0, 32'h13, 32'h0));
    q0.push_back(mk(0, 3'd2, 1, 32'h13, 32'h0));
    q0.push_back(mk(0, 3'd0, 0, 32'h6, 32'h0));
    q0.push_back(mk(1, 3'd1, 0, 32'h11, 32'h1234));
    q0.push_back(mk(0, 3'd3, 0, 32'h10, 32'h0));
    q0.push_back(mk(0, 3'd0, 0, 32'h4000, 32'h0));
    q1.push_back(mk(1, 3'd1, 0, 32'h22, 32'h0000BEEF));
    q1.push_back(mk(1, 3'd2, 0, 32'h13, 32'h00000080));
    q1.push_back(mk(0, 3'd1, 0, 32'h22, 32'h0));
    q1.push_back(mk(0, 3'd1, 1, 32'h22, 32'h0));
    q1.push_back(mk(1, 3'd1, 0, 32'h12, 32'h0000BEEF));
    q1.push_back(mk(0, 3'd0, 0, 32'h10, 32'h0));
    drivers();
    model_arb();
    drain(300);
    for (int i = 0; i < 250; i++) begin
      q0.push_back(rand_tx());
      q1.push_back(rand_tx());
    end
    drain(20000);
    inject_armed = 1;
    q1.push_back(mk(1, 3'd2, 0, 32'h3F01, 32'h000000AA));
    drain(50);
    chk("abort_consumed", 32'(inject_armed), 0);
    q0.push_back(mk(0, 3'd0, 0, 32'h3F00, 32'h0));
    q1.push_back(mk(0, 3'd0, 0, 32'h3F00, 32'h0));
    drain(50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Sequences the single-port data-memory SRAM and shares it between two requesters: the CPU MEM stage (port c) and an external bridge/DMA port (port d).
- Per access it:
  - arbitrates round-robin between the two ports;
  - generates byte-lane write enables and lane-replicated write data for word/half/byte stores;
  - extracts, aligns and sign/zero-extends load data;
  - flags misaligned, out-of-range or illegal-size accesses without touching memory.
- Sits between the pipeline/bridge and the data-memory array; the CPU stalls while c_req is high and c_done is low.

Parameters:
- DM_WORDS, 4096, number of 32-bit words in the data memory.
- ADDR_W, 12, word-address width (log2 of DM_WORDS).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- c_req  input  1  CPU access request; held until c_done
- c_we  input  1  1 = store, 0 = load
- c_size  input  3  000 word, 001 half, 010 byte; others illegal
- c_uns  input  1  load zero-extend (1) or sign-extend (0)
- c_addr  input  32  byte address
- c_wdata  input  32  store data, low-aligned
- c_done  output  1  one-cycle completion pulse
- c_rdata  output  32  extended load data, valid with c_done
- c_err  output  1  access fault, valid with c_done
- d_req, d_we, d_size, d_uns, d_addr, d_wdata, d_done, d_rdata, d_err: same directions, widths and meanings for the DMA port
- mem_en  output  1  SRAM enable
- mem_be  output  4  SRAM byte write enables (0000 = read)
- mem_addr  output  ADDR_W  SRAM word address
- mem_wdata  output  32  SRAM write data
- mem_rdata  input  32  SRAM read data, valid one cycle after mem_en

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE;
  - last_grant = d, so c wins the first contention.
- Reset mid-access aborts the access: no done pulse is issued and the SRAM is idle in the cycle after reset.
- States:
  - IDLE:
    - if any request, pick the winner, latch its fields into an internal request register, go to CHECK;
    - otherwise stay.
  - CHECK:
    - fault if any of: size illegal; half with addr[0]=1; word with addr[1:0]≠0; addr[31:ADDR_W+2]≠0;
    - fault → go to RESP with err set, no SRAM access;
    - else drive mem_en=1, mem_addr=addr[ADDR_W+1:2], then go to RESP;
    - store mem_be: word 1111; half addr[1]?1100:0011; byte 0001<<addr[1:0];
    - store mem_wdata: word as-is; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}};
    - load: mem_be=0000.
  - RESP:
    - winner's done=1 for exactly this cycle; err per CHECK;
    - load rdata = lane selected by addr[1:0] (half by addr[1]), extended per uns;
    - store rdata = 0; err=1 forces rdata=0;
    - update last_grant; go to IDLE.
- Arbitration:
  - sole requester wins;
  - both requesting: the port ≠ last_grant wins.
- Latency: request in IDLE at cycle N → done at N+2. Back-to-back throughput is one access per 3 cycles.
- Requester must hold req/fields stable until done. It may keep req high after done to start a new access, which is sampled in the following IDLE cycle.
- The loser keeps waiting. Fairness: with both ports requesting continuously, grants alternate c,d,c,d.
- Fields are latched in IDLE; changes to an in-flight port's inputs after that are ignored.
- The non-granted port's done/err/rdata stay 0.
- Write-after-read hazards are impossible: a single access is in flight at a time.

Decomposition:
- Shared package dm_pkg:
  - size codes SZ_WORD=3'b000, SZ_HALF=3'b001, SZ_BYTE=3'b010;
  - state encoding IDLE/CHECK/RESP;
  - DM_WORDS/ADDR_W defaults.
- One natural sub-module, dm_lane_unit (combinational): from size/addr/wdata/rdata/uns it produces be, wdata_rep, rdata_ext and misalign. It is instantiated once on the latched request.

Test Plan:
- Word store and reload:
  - c store word 0x12345678 @0x00000010 → CHECK cycle mem_be=1111, mem_addr=4, c_done at N+2;
  - c load @0x10 → c_rdata=0x12345678.
- Byte and half extension:
  - d store byte 0x80 @0x13 → mem_be=1000, mem_wdata=0x80808080;
  - c load byte signed @0x13 → 0xFFFFFF80; unsigned → 0x00000080;
  - store half 0xBEEF @0x12 → mem_be=1100.
- Faults, each giving c_err=1, c_rdata=0, mem_en never asserted:
  - c load word @0x00000006;
  - c store half @0x00000011;
  - size 3'b011;
  - addr 0x00004000 with ADDR_W=12.
- Contention: c_req and d_req both held high for 12 cycles from reset → grant order c,d,c,d; done pulses at cycles 2,5,8,11 relative to first sample.
- Reset mid-access: assert reset during CHECK of a d store → no d_done; the following c load is serviced normally with last_grant=d behaviour.
